// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-stage PC generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_EXC  = 3'd0,
        SEL_ERET = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_BR   = 3'd3,
        SEL_SEQ  = 3'd4,
        SEL_HOLD = 3'd5
    } pc_sel_e;

    localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VEC_DEF   = 32'h0000_0080;

    function automatic logic sel_is_redirect(input pc_sel_e sel);
        return (sel == SEL_EXC) || (sel == SEL_ERET) || (sel == SEL_JMP) || (sel == SEL_BR);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority encoder and mux.
// PC_ALIGN_CHECK_EN: misaligned eret/jump/branch targets are converted to exceptions.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned     PC_W    = 32,
    parameter logic [PC_W-1:0] EXC_VEC = PC_W'(PC_EXC_VEC_DEF),
    parameter int unsigned     STEP    = 4
) (
    input  pc_state_e         state_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [PC_W-1:0]   epc_i,
    input  logic              write_in,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    input  logic              jump_in,
    input  logic [PC_W-1:0]   jump_target,
    input  logic              exc_in,
    input  logic              eret_in,
    input  logic              halt_in,
    output pc_sel_e           sel_o,
    output logic [PC_W-1:0]   pc_next_o,
    output logic [PC_W-1:0]   epc_val_o,
    output logic              misalign_o
);

    logic [PC_W-1:0] tgt;
    logic            tgt_vld;
    pc_sel_e         tgt_sel;

    always_comb begin
        tgt     = '0;
        tgt_vld = 1'b0;
        tgt_sel = SEL_HOLD;
        if (eret_in) begin
            tgt = epc_i; tgt_vld = 1'b1; tgt_sel = SEL_ERET;
        end else if (jump_in) begin
            tgt = jump_target; tgt_vld = 1'b1; tgt_sel = SEL_JMP;
        end else if (branch_taken) begin
            tgt = branch_target; tgt_vld = 1'b1; tgt_sel = SEL_BR;
        end
    end

    always_comb begin
        sel_o      = SEL_HOLD;
        pc_next_o  = pc_i;
        epc_val_o  = pc_i;
        misalign_o = 1'b0;
        unique case (state_i)
            RUN: begin
                // halt outranks every redirect except an exception
                if (exc_in) begin
                    sel_o = SEL_EXC; pc_next_o = EXC_VEC;
                end else if (halt_in) begin
                    sel_o = SEL_HOLD;
                end else if (tgt_vld) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (tgt[1:0] != 2'b00) begin
                        sel_o = SEL_EXC; pc_next_o = EXC_VEC;
                        epc_val_o = tgt; misalign_o = 1'b1;
                    end else begin
                        sel_o = tgt_sel; pc_next_o = tgt;
                    end
`else
                    sel_o = tgt_sel; pc_next_o = tgt;
`endif
                end else if (write_in) begin
                    sel_o = SEL_SEQ; pc_next_o = pc_i + PC_W'(STEP);
                end
            end
            HALT: begin
                if (exc_in) begin
                    sel_o = SEL_EXC; pc_next_o = EXC_VEC;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: BOOT/RUN/HALT FSM, PC, EPC, redirect pulses.
// PC_ALIGN_CHECK_EN: enables misaligned-target trapping (misalign_out otherwise stays 0).
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(PC_RESET_VEC_DEF),
    parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(PC_EXC_VEC_DEF),
    parameter int unsigned     STEP      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_in,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    input  logic              jump_in,
    input  logic [PC_W-1:0]   jump_target,
    input  logic              exc_in,
    input  logic              eret_in,
    input  logic              halt_in,
    output logic [PC_W-1:0]   PC_out,
    output logic [PC_W-1:0]   PC_plus_out,
    output logic [PC_W-1:0]   epc_out,
    output logic              pc_valid_out,
    output logic              redirect_out,
    output logic              misalign_out
);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic            valid_q, valid_d;
    logic            redirect_q, redirect_d;
    logic            misalign_q, misalign_d;

    pc_sel_e         sel;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] epc_val;
    logic            misalign;

    pc_next_sel #(
        .PC_W    (PC_W),
        .EXC_VEC (EXC_VEC),
        .STEP    (STEP)
    ) u_next_sel (
        .state_i       (state_q),
        .pc_i          (pc_q),
        .epc_i         (epc_q),
        .write_in      (write_in),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_in       (jump_in),
        .jump_target   (jump_target),
        .exc_in        (exc_in),
        .eret_in       (eret_in),
        .halt_in       (halt_in),
        .sel_o         (sel),
        .pc_next_o     (pc_next),
        .epc_val_o     (epc_val),
        .misalign_o    (misalign)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN:  if (sel != SEL_EXC && halt_in) state_d = HALT;
            HALT: if (sel == SEL_EXC) state_d = RUN;
            default: state_d = BOOT;
        endcase
        pc_d       = pc_next;
        epc_d      = (sel == SEL_EXC) ? epc_val : epc_q;
        valid_d    = (state_d == RUN);
        redirect_d = sel_is_redirect(sel);
        misalign_d = misalign;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            valid_q    <= 1'b0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            valid_q    <= valid_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
        end
    end

    assign PC_out       = pc_q;
    assign PC_plus_out  = pc_q + PC_W'(STEP);
    assign epc_out      = epc_q;
    assign pc_valid_out = valid_q;
    assign redirect_out = redirect_q;
    assign misalign_out = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (default parameters; either build of PC_ALIGN_CHECK_EN).
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_in, branch_taken, jump_in, exc_in, eret_in, halt_in;
    logic [31:0] branch_target, jump_target;
    logic [31:0] PC_out, PC_plus_out, epc_out;
    logic        pc_valid_out, redirect_out, misalign_out;

    int unsigned errors = 0;
    int unsigned checks = 0;

    pc_gen dut (
        .clk           (clk),
        .rst           (rst),
        .write_in      (write_in),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_in       (jump_in),
        .jump_target   (jump_target),
        .exc_in        (exc_in),
        .eret_in       (eret_in),
        .halt_in       (halt_in),
        .PC_out        (PC_out),
        .PC_plus_out   (PC_plus_out),
        .epc_out       (epc_out),
        .pc_valid_out  (pc_valid_out),
        .redirect_out  (redirect_out),
        .misalign_out  (misalign_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_in = 1'b0; branch_taken = 1'b0; jump_in = 1'b0;
        exc_in = 1'b0; eret_in = 1'b0; halt_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        branch_target = '0;
        jump_target   = '0;
        write_in      = 1'b1;
        #2;
        chk("rst_pc",       PC_out,       32'h0);
        chk("rst_epc",      epc_out,      32'h0);
        chk("rst_valid",    pc_valid_out, 32'h0);
        chk("rst_redirect", redirect_out, 32'h0);
        chk("rst_misalign", misalign_out, 32'h0);
        tick();
        rst = 1'b0;

        // boot edge holds RESET_VEC, then sequential steps
        tick(); chk("boot_pc", PC_out, 32'h0); chk("boot_valid", pc_valid_out, 32'h1);
        tick(); chk("seq1_pc", PC_out, 32'h4); chk("seq1_valid", pc_valid_out, 32'h1);
        tick(); chk("seq2_pc", PC_out, 32'h8); chk("seq2_plus", PC_plus_out, 32'hC);
        tick(); tick(); chk("seq4_pc", PC_out, 32'h10);
        chk("seq_no_redirect", redirect_out, 32'h0);

        // branch under stall
        write_in = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
        tick(); chk("br_pc", PC_out, 32'h40); chk("br_redirect", redirect_out, 32'h1);
        idle();
        tick(); chk("br_hold_pc", PC_out, 32'h40); chk("br_pulse_end", redirect_out, 32'h0);

        // exception beats jump and branch; eret restores without touching epc
        jump_in = 1'b1; jump_target = 32'h20;
        tick(); chk("jmp_pc", PC_out, 32'h20); chk("jmp_redirect", redirect_out, 32'h1);
        exc_in = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h200;
        tick(); chk("exc_pc", PC_out, 32'h80); chk("exc_epc", epc_out, 32'h20);
        chk("exc_redirect", redirect_out, 32'h1);
        idle(); eret_in = 1'b1;
        tick(); chk("eret_pc", PC_out, 32'h20); chk("eret_epc", epc_out, 32'h20);
        chk("eret_redirect", redirect_out, 32'h1);

        // wrap at top of address space
        idle(); jump_in = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick(); chk("top_pc", PC_out, 32'hFFFF_FFFC); chk("top_plus", PC_plus_out, 32'h0);
        idle(); write_in = 1'b1;
        tick(); chk("wrap_pc", PC_out, 32'h0); chk("wrap_plus", PC_plus_out, 32'h4);
        chk("wrap_redirect", redirect_out, 32'h0);

        // halt at 0x8, ignore everything but exc
        tick(); tick(); chk("pre_halt_pc", PC_out, 32'h8);
        halt_in = 1'b1;
        tick(); chk("halt_pc", PC_out, 32'h8); chk("halt_valid", pc_valid_out, 32'h0);
        halt_in = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
        jump_in = 1'b1; jump_target = 32'h60; eret_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halted_pc", PC_out, 32'h8);
            chk("halted_valid", pc_valid_out, 32'h0);
            chk("halted_redirect", redirect_out, 32'h0);
        end
        idle(); exc_in = 1'b1;
        tick(); chk("wake_pc", PC_out, 32'h80); chk("wake_valid", pc_valid_out, 32'h1);
        chk("wake_epc", epc_out, 32'h8); chk("wake_redirect", redirect_out, 32'h1);

        // misaligned jump target
        idle(); jump_in = 1'b1; jump_target = 32'h42;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_pc", PC_out, 32'h80); chk("mis_epc", epc_out, 32'h42);
        chk("mis_flag", misalign_out, 32'h1);
`else
        chk("mis_pc", PC_out, 32'h42); chk("mis_epc", epc_out, 32'h8);
        chk("mis_flag", misalign_out, 32'h0);
`endif
        chk("mis_redirect", redirect_out, 32'h1);
        idle();
        tick(); chk("mis_pulse_end", misalign_out, 32'h0);
        chk("mis_redirect_end", redirect_out, 32'h0);

        // asynchronous reset mid-redirect
        jump_in = 1'b1; jump_target = 32'h300;
        tick(); chk("pre_rst_pc", PC_out, 32'h300); chk("pre_rst_redirect", redirect_out, 32'h1);
        jump_target = 32'h400;
        #2 rst = 1'b1;
        #1;
        chk("arst_pc",       PC_out,       32'h0);
        chk("arst_epc",      epc_out,      32'h0);
        chk("arst_valid",    pc_valid_out, 32'h0);
        chk("arst_redirect", redirect_out, 32'h0);
        chk("arst_misalign", misalign_out, 32'h0);
        idle();
        tick();
        rst = 1'b0;
        tick(); chk("rerun_pc", PC_out, 32'h0); chk("rerun_valid", pc_valid_out, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
